// File: rtl/range_sum_seq.sv
`default_nettype none
// ============================================================================
// range_sum_seq : sums the 4-bit operands I[lo..hi], one per clock, into Y.
// Revision 1.0
// ============================================================================
module range_sum_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] Iin,
  input  logic [2:0]  M,
  input  logic [2:0]  m,
  output logic        busy,
  output logic        done,
  output logic [7:0]  Y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] opnd_q, opnd_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  hi_q, hi_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  y_q, y_d;

  logic [3:0]  cur_nib;
  logic [7:0]  sum;
  logic [2:0]  lo_in;
  logic [2:0]  hi_in;

  assign cur_nib = opnd_q[{idx_q, 2'b00} +: 4];
  assign sum     = acc_q + {4'b0000, cur_nib};
  assign lo_in   = (M < m) ? M : m;
  assign hi_in   = (M < m) ? m : M;

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d  = Iin;
          idx_d   = lo_in;
          hi_d    = hi_in;
          acc_d   = 8'h00;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = sum;
        // idx stops at hi, so it never wraps past 7
        if (idx_q == hi_q) begin
          y_d     = sum;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opnd_q  <= 32'h0000_0000;
      idx_q   <= 3'd0;
      hi_q    <= 3'd0;
      acc_q   <= 8'h00;
      y_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign Y    = y_q;

endmodule
`default_nettype wire

// File: tb/tb_range_sum_seq.sv
`default_nettype none
// ============================================================================
// tb_range_sum_seq : randomized and directed checks of range_sum_seq.
// Revision 1.0
// ============================================================================
module tb_range_sum_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] Iin;
  logic [2:0]  M;
  logic [2:0]  m;
  logic        busy;
  logic        done;
  logic [7:0]  Y;

  int checks;
  int errors;

  range_sum_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Iin   (Iin),
    .M     (M),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain sum of the selected nibbles over the ordered range
  function automatic logic [7:0] ref_sum(input logic [31:0] iin, input int a, input int b);
    int lo, hi, s;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    s  = 0;
    for (int k = lo; k <= hi; k++) s += (iin >> (4 * k)) & 15;
    return s[7:0];
  endfunction

  task automatic do_req(input logic [31:0] iin, input int a, input int b,
                        input bit disturb, input string tag);
    logic [7:0] exp_y;
    logic [7:0] y_prev;
    int         n;
    int         cyc;
    exp_y = ref_sum(iin, a, b);
    n     = ((a > b) ? a - b : b - a) + 1;
    @(negedge clk);
    Iin    = iin;
    M      = a[2:0];
    m      = b[2:0];
    start  = 1'b1;
    y_prev = Y;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Inputs scrambled and start held high while busy must not matter
    if (disturb) begin
      Iin   = $urandom;
      M     = 3'($urandom_range(0, 7));
      m     = 3'($urandom_range(0, 7));
      start = 1'b1;
    end
    cyc = 0;
    while (!done && cyc < 20) begin
      check({tag, "_busy_acc"}, busy, 1);
      check({tag, "_y_hold"}, Y, y_prev);
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, n);
    check({tag, "_y"}, Y, exp_y);
    check({tag, "_busy_done"}, busy, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_y_keep"}, Y, exp_y);
    @(posedge clk);
    #1;
    check({tag, "_no_second"}, done | busy, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    Iin    = 32'h0;
    M      = 3'd0;
    m      = 3'd0;
    #1;
    check("reset_y", Y, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_req(32'h76543210, 6, 6, 1'b0, "single");
    do_req(32'hFFFFFFFF, 0, 7, 1'b0, "full_fwd");
    do_req(32'hFFFFFFFF, 7, 0, 1'b0, "full_rev");
    do_req(32'h76543210, 5, 4, 1'b0, "rev_54");
    do_req(32'h76543210, 1, 2, 1'b0, "fwd_12");
    do_req(32'h76543210, 0, 7, 1'b1, "busy_reject");
    do_req(32'h76543210, 0, 3, 1'b1, "input_hold");

    // Reset in the middle of a long request
    @(negedge clk);
    Iin   = 32'h76543210;
    M     = 3'd0;
    m     = 3'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_y", Y, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(32'h76543210, 2, 2, 1'b0, "after_rst");

    for (int t = 0; t < 40; t++) begin
      do_req($urandom, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/range_sum_seq.md
RANGE_SUM_SEQ -- requirements
Module: range_sum_seq

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, single system clock, all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have the port `start`: input, 1 bit, request strobe, sampled only in IDLE.
REQ-004 The block SHALL have the port `Iin`: input, 32 bits, eight packed 4-bit operands, I[k] = Iin[4k+3:4k], k=0..7.
REQ-005 The block SHALL have the port `M`: input, 3 bits, range bound A.
REQ-006 The block SHALL have the port `m`: input, 3 bits, range bound B.
REQ-007 The block SHALL have the port `busy`: output, 1 bit, high while a request is in progress (ACC or DONE).
REQ-008 The block SHALL have the port `done`: output, 1 bit, one-cycle pulse marking Y updated.
REQ-009 The block SHALL have the port `Y`: output, 8 bits, registered result = sum of I[lo..hi], held until the next result.
REQ-010 The block SHALL use one clock; reset SHALL be asynchronous and active-low, named `rst_n`; the clock SHALL be named `clk`.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, ACC and DONE.
REQ-012 In IDLE with start=1 at rising edge E0, the block SHALL:
- latch Iin;
- set lo=min(M,m), hi=max(M,m), idx=lo, acc=0;
- move to ACC.
REQ-013 In ACC, each edge SHALL compute acc <= acc + {4'b0, I[idx]}.
- If idx==hi: move to DONE, load Y with the final sum, and set done=1.
- Otherwise: idx <= idx+1.
REQ-014 With n = hi-lo+1 (1..8), done SHALL go high at edge E0+n and low at edge E0+n+1; the FSM SHALL return to IDLE at edge E0+n+1.
REQ-015 Y SHALL change only on the edge that enters DONE, and SHALL hold its value in all other states.
REQ-016 Arithmetic SHALL be 8-bit unsigned; the maximum sum is 8*15=120, so no overflow or saturation logic is required.
REQ-017 M==m SHALL take exactly one ACC cycle, with Y=I[M].
REQ-018 M>m and M<m SHALL give identical results (order-independent range).
REQ-019 idx SHALL never increment past hi and SHALL never wrap past 7.
REQ-020 start in ACC or DONE SHALL be ignored, with no queuing. start in IDLE on the edge leaving DONE is not possible; the first accepted start after a result is at edge E0+n+2 or later.
REQ-021 Changes on Iin, M and m after E0 SHALL NOT affect the request in progress.
REQ-022 busy SHALL be 1 in ACC and DONE and 0 in IDLE; it SHALL be decoded from state, not registered separately.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, acc=0, idx=0, Y=8'h00, done=0 and busy=0, regardless of the clock.
REQ-024 Reset asserted mid-request SHALL abort it, with no done pulse and Y=0.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-026 Single element: Iin=32'h76543210, M=6, m=6, start pulse -> done at E0+1, Y=8'd6, busy high 2 cycles.
REQ-027 Full range, both orders:
- Iin=32'hFFFFFFFF, M=0, m=7 -> done at E0+8, Y=8'd120.
- Then M=7, m=0 -> same Y and same timing.
REQ-028 Reversed bounds: Iin=32'h76543210, M=5, m=4 -> done at E0+2, Y=8'd9; M=1, m=2 -> Y=8'd3.
REQ-029 Busy rejection: start M=0, m=7 with Iin=32'h76543210, then pulse start with M=3, m=3 at E0+3 -> single done at E0+8, Y=8'd28, no second done.
REQ-030 Reset mid-operation: start M=0, m=7, assert rst_n=0 between E0+3 and E0+4 -> Y=0, done=0, busy=0 immediately; a new request M=2, m=2 with Iin=32'h76543210 -> Y=8'd2.
REQ-031 Input hold: change Iin to 0 one cycle after E0 for M=0, m=3, Iin=32'h76543210 -> Y=8'd6 (latched operands used).
